// File: rtl/point_dispatcher_if.sv
// Point/control bus around the point dispatcher: pass control from the host,
// the read port of the point RAM, and the point/control lines into the root
// of the PE tree. The master side is the dispatcher itself.
interface point_dispatcher_if #(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int max_n      = 1000,
    parameter int max_depth  = 16
);
    localparam int dim_size     = $clog2(data_range);
    localparam int counter_size = $clog2(max_n);
    localparam int depth_size   = $clog2(max_depth);
    localparam int center_size  = dim * dim_size;

    logic                    start;
    logic [counter_size-1:0] n_points;
    logic [depth_size-1:0]   tree_depth;
    logic                    mem_rd_en;
    logic [counter_size-1:0] mem_addr;
    logic                    mem_rd_valid;
    logic [center_size-1:0]  mem_rd_data;
    logic                    en;
    logic [center_size-1:0]  point_out;
    logic                    receive_point;
    logic                    sorting;
    logic                    go_left;
    logic                    next_level;
    logic                    inc;
    logic [depth_size-1:0]   level;
    logic [max_depth-1:0]    path;
    logic [counter_size-1:0] points_sent;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, n_points, tree_depth, mem_rd_valid, mem_rd_data, go_left,
        output mem_rd_en, mem_addr, en, point_out, receive_point, sorting,
               next_level, inc, level, path, points_sent, busy, done
    );

    modport slave (
        output start, n_points, tree_depth, mem_rd_valid, mem_rd_data, go_left,
        input  mem_rd_en, mem_addr, en, point_out, receive_point, sorting,
               next_level, inc, level, path, points_sent, busy, done
    );
endinterface

// File: rtl/point_dispatcher.sv
// Streams points from the point RAM into the kd-tree of cluster PEs: fetch a
// point, broadcast it, walk it down one level per SORT/STEP pair using the
// PEs' go_left answers, then strobe inc at the leaf.
module point_dispatcher #(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int max_n      = 1000,
    parameter int max_depth  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    point_dispatcher_if.master io_bus
);
    localparam int dim_size     = $clog2(data_range);
    localparam int counter_size = $clog2(max_n);
    localparam int depth_size   = $clog2(max_depth);
    localparam int center_size  = dim * dim_size;
    localparam logic [depth_size:0] maxLevelWide = (depth_size + 1)'(max_depth - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_BCAST, S_SORT, S_STEP, S_INC, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [counter_size-1:0] r_nPoints;
    logic [counter_size-1:0] r_index;
    logic [counter_size-1:0] r_pointsSent;
    logic [depth_size-1:0]   r_depth;
    logic [depth_size-1:0]   r_level;
    logic [center_size-1:0]  r_captured;
    logic [center_size-1:0]  r_pointOut;
    logic [max_depth-1:0]    r_path;

    logic [depth_size-1:0]   w_depthClamped;
    logic [counter_size:0]   w_indexInc;
    logic [depth_size:0]     w_levelInc;
    logic                    w_lastPoint;
    logic                    w_lastLevel;
    logic                    w_memRdEn;
    logic                    w_en;
    logic                    w_receivePoint;
    logic                    w_sorting;
    logic                    w_nextLevel;
    logic                    w_inc;
    logic                    w_busy;
    logic                    w_done;

    // Depths deeper than the tree can hold are clamped to the deepest level.
    assign w_depthClamped = ({1'b0, io_bus.tree_depth} > maxLevelWide)
                          ? maxLevelWide[depth_size-1:0] : io_bus.tree_depth;

    // Widened increments so the end-of-pass / end-of-walk compares cannot wrap.
    assign w_indexInc  = {1'b0, r_index} + (counter_size + 1)'(1);
    assign w_levelInc  = {1'b0, r_level} + (depth_size + 1)'(1);
    assign w_lastPoint = (w_indexInc == {1'b0, r_nPoints});
    assign w_lastLevel = (w_levelInc == {1'b0, r_depth});

    // State register; reset drops any pass in flight, including a pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and Moore strobes decoded from the registered state.
    always_comb begin
        w_nextState    = r_state;
        w_memRdEn      = 1'b0;
        w_receivePoint = 1'b0;
        w_sorting      = 1'b0;
        w_nextLevel    = 1'b0;
        w_inc          = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_nextState = (io_bus.n_points == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_memRdEn   = 1'b1;
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (io_bus.mem_rd_valid) begin
                    w_nextState = S_BCAST;
                end
            end
            S_BCAST: begin
                w_receivePoint = 1'b1;
                w_nextState    = (r_depth == '0) ? S_INC : S_SORT;
            end
            S_SORT: begin
                w_sorting   = 1'b1;
                w_nextState = S_STEP;
            end
            S_STEP: begin
                w_nextLevel = 1'b1;
                w_nextState = w_lastLevel ? S_INC : S_SORT;
            end
            S_INC: begin
                w_inc       = 1'b1;
                w_nextState = w_lastPoint ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        w_en   = (r_state != S_IDLE) && (r_state != S_DONE);
        w_busy = (r_state != S_IDLE);
    end

    // Datapath registers, each updated only in the state that owns it. On the
    // final STEP the level is left at the deepest level actually sorted, so it
    // never points past the leaf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nPoints    <= '0;
            r_index      <= '0;
            r_pointsSent <= '0;
            r_depth      <= '0;
            r_level      <= '0;
            r_captured   <= '0;
            r_pointOut   <= '0;
            r_path       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_nPoints    <= io_bus.n_points;
                        r_depth      <= w_depthClamped;
                        r_index      <= '0;
                        r_pointsSent <= '0;
                    end
                end
                S_WAIT: begin
                    if (io_bus.mem_rd_valid) begin
                        r_captured <= io_bus.mem_rd_data;
                    end
                end
                S_BCAST: begin
                    r_pointOut <= r_captured;
                    r_level    <= '0;
                    r_path     <= '0;
                end
                S_SORT: begin
                    r_path[r_level] <= io_bus.go_left;
                end
                S_STEP: begin
                    if (!w_lastLevel) begin
                        r_level <= w_levelInc[depth_size-1:0];
                    end
                end
                S_INC: begin
                    r_index      <= w_indexInc[counter_size-1:0];
                    r_pointsSent <= r_pointsSent + counter_size'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.mem_rd_en     = w_memRdEn;
    assign io_bus.mem_addr      = r_index;
    assign io_bus.en            = w_en;
    assign io_bus.point_out     = r_pointOut;
    assign io_bus.receive_point = w_receivePoint;
    assign io_bus.sorting       = w_sorting;
    assign io_bus.next_level    = w_nextLevel;
    assign io_bus.inc           = w_inc;
    assign io_bus.level         = r_level;
    assign io_bus.path          = r_path;
    assign io_bus.points_sent   = r_pointsSent;
    assign io_bus.busy          = w_busy;
    assign io_bus.done          = w_done;
endmodule

// File: doc/point_dispatcher.md
# point_dispatcher

Streams data points from point memory into the kd-tree of cluster PEs, one point at a time. For each point it fetches the point, broadcasts it to the tree, and walks it down one tree level per step using the PEs' `go_left` decisions. It then commands the accumulate strobe at the leaf. It is the sending side of the PE point/control interface (`point_in`, `receive_point`, `sorting`, `next_level`, `inc`, `en`) and sits between the point RAM and the root of the tree.

## Interface
Parameters:
- `dim`, 3: dimensions per point; the layout fixes this at 3.
- `data_range`, 255: maximum coordinate value. `dim_size = $clog2(data_range)` (8 at default).
- `max_n`, 1000: maximum points per pass. `counter_size = $clog2(max_n)` (10).
- `max_depth`, 16: maximum tree depth. `depth_size = $clog2(max_depth)` (4).
- Derived: `center_size = dim*dim_size` (24). Dimension k occupies `[k*dim_size +: dim_size]`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a pass. Sampled only in IDLE.
- `n_points`  in  counter_size  points in the pass. Latched at `start`.
- `tree_depth`  in  depth_size  levels to traverse. Latched at `start`.
- `mem_rd_en`  out  1  single-cycle read request.
- `mem_addr`  out  counter_size  read address, equal to the current point index.
- `mem_rd_valid`  in  1  read data valid. Honoured only in WAIT.
- `mem_rd_data`  in  center_size  point read from memory.
- `en`  out  1  PE enable. High in every state except IDLE and DONE.
- `point_out`  out  center_size  current point, held stable from BCAST until the next BCAST.
- `receive_point`  out  1  one-cycle pulse in BCAST.
- `sorting`  out  1  high in SORT.
- `go_left`  in  1  PE decision for the current level. Sampled in SORT.
- `next_level`  out  1  one-cycle pulse in STEP.
- `inc`  out  1  one-cycle pulse in INC.
- `level`  out  depth_size  current tree level.
- `path`  out  max_depth  decision history. Bit i = `go_left` sampled at level i.
- `points_sent`  out  counter_size  count of INC pulses issued in this pass.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
States: IDLE, FETCH, WAIT, BCAST, SORT, STEP, INC, DONE.

Transitions:
- IDLE: on `start`, latch `n_points` and `tree_depth`, and clear the point index and `points_sent`.
  - If `n_points==0`, go to DONE.
  - Otherwise go to FETCH.
- FETCH: `mem_rd_en=1`, `mem_addr=index`. Go to WAIT.
- WAIT: on `mem_rd_valid`, capture `mem_rd_data` and go to BCAST.
- BCAST: `point_out` takes the captured data; `receive_point=1`; `level` and `path` are cleared.
  - If latched depth is 0, go to INC.
  - Otherwise go to SORT.
- SORT: `sorting=1`. Write `path[level] <= go_left`. Go to STEP.
- STEP: `next_level=1`. Increment `level`.
  - If `level+1 == depth`, go to INC.
  - Otherwise go to SORT.
- INC: `inc=1`. Increment the index and `points_sent`.
  - If the new index equals `n_points`, go to DONE.
  - Otherwise go to FETCH.
- DONE: `done=1`. Go to IDLE.

Output generation:
- All strobes and `en`/`busy` decode from the registered state only (Moore).
- `level`, `path`, `point_out`, `mem_addr` and `points_sent` are registers.

Boundary conditions:
- `start` while busy: ignored.
- `mem_rd_valid` outside WAIT: ignored, and the data is not captured.
- A `tree_depth` value greater than `max_depth-1` is clamped to `max_depth-1` at latch time.
- `path` bits at positions ≥ depth stay 0.
- Counters never wrap: `n_points` ≤ `max_n` is guaranteed by the caller.

Reset:
- Asserting `rst_n` low, at any time including mid-pass, immediately forces state to IDLE.
- Every output goes to 0: `point_out`, `path`, `level`, `mem_addr`, `points_sent`, and all strobes.
- No pending read is remembered. The first WAIT after a restart accepts only new `mem_rd_valid` pulses.

## Timing
- `start` sampled at edge t. FETCH occupies cycle t+1, and `mem_rd_en` is high only in that cycle.
- `mem_rd_valid` is accepted no earlier than the cycle after FETCH. With memory latency L≥1 the bench sees L cycles in WAIT.
- Cycles per point: 1 (FETCH) + L + 1 (BCAST) + 2·depth + 1 (INC).
  - With depth=2 and L=1: 8 cycles.
  - With depth=0 and L=1: 4 cycles.
- `go_left` must be valid in the SORT cycle. Its value in any other cycle has no effect.
- `done` pulses one cycle after the last INC. `busy` falls the cycle after `done`.
- `n_points==0`: `done` occurs at t+1, with no `mem_rd_en`, `receive_point` or `inc`.

## Test plan
- **Two-level walk.** Stimulus: n=1, depth=2, L=1, memory[0]=[10,20,30]; `go_left`=1 at level 0, 0 at level 1.
  - Required: `point_out` shows 10/20/30 in the dim 0/1/2 fields.
  - Required: `receive_point` pulses once, then `sorting`/`next_level` twice each, then one `inc`.
  - Required: `path`=…0001b, `points_sent`=1, `done` at t+9.
- **Empty pass.** n=0 → `done` at t+1, `busy` high for 1 cycle only, zero memory reads.
- **Zero depth.** depth=0, n=3, L=1 → three `inc` pulses 4 cycles apart, `sorting` never high, `mem_addr` sequence 0,1,2.
- **Slow memory.** L=5, with stray `mem_rd_valid` pulses in SORT.
  - Required: stall exactly 5 cycles in WAIT; stray pulses change neither `point_out` nor state.
  - Required: `start` pulses while busy are ignored.
- **Reset mid-SORT.** `rst_n` low during SORT of point 2 → all outputs 0 asynchronously. A subsequent clean pass with n=2 completes with `points_sent`=2.
- **Maximum depth.** `tree_depth`=15, alternating `go_left` → `path`=0x5555 (bit 15 = 0), `level` reaches 14 and then returns to 0 at the next BCAST.
